de_alu_issue: RTL
=================

# de_alu_issue

Decode-and-issue stage for the ALU in the P5 pipeline. Decodes the D-stage instruction into an ALU operation code, selects and extends the two ALU operands, and registers them with the matching write-back and memory controls into the E stage. It produces `ALU_ctrl_E`, `ALU_srca_E` and `ALU_srcb_E` for the execute-stage ALU. It also owns E-stage bubble insertion (flush) and hold (stall).

## Interface
Parameters:
- `BUBBLE_CTRL`, default 3'b011: ALU code issued for bubbles and illegal instructions. The ALU outputs 0 for this code.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces a bubble into E.
- `Instr_D_i`  in  32  D-stage instruction word.
- `RD1_D_i`  in  32  rs value, already forwarded.
- `RD2_D_i`  in  32  rt value, already forwarded.
- `stall_E_i`  in  1  hold all E registers.
- `flush_E_i`  in  1  load a bubble into E.
- `ALU_ctrl_E_o`  out  3  ALU operation code.
- `ALU_srca_E_o`  out  32  ALU operand A.
- `ALU_srcb_E_o`  out  32  ALU operand B.
- `WA_E_o`  out  5  write-back register address.
- `RegWrite_E_o`  out  1  register write enable.
- `MemWrite_E_o`  out  1  store.
- `MemToReg_E_o`  out  1  load result selects memory.
- `Valid_E_o`  out  1  E holds a real instruction.
- `Illegal_E_o`  out  1  E holds an undecodable instruction.

## Operation
ALU codes:
- 000 and; 001 or; 010 add; 011 zero; 100 and-not; 101 or-not; 110 sub; 111 shift left (A << B).

Decode, with op = `Instr[31:26]`, funct = `Instr[5:0]`, zext/sext of `imm[15:0]`:
- op 0, funct 100001 (addu): ctrl 010. A=RD1, B=RD2. WA=rd. RegWrite.
- op 0, funct 100011 (subu): ctrl 110. Otherwise same as addu.
- op 0, funct 100100 (and): ctrl 000. op 0, funct 100101 (or): ctrl 001. Both use the R-type operands and write rd.
- op 0, funct 000000 (sll): ctrl 111. A=RD2. B={27'b0, shamt}. WA=rd.
- op 001101 (ori): ctrl 001. A=RD1. B=zext imm. WA=rt.
- op 001111 (lui): ctrl 111. A=zext imm. B=32'd16. WA=rt.
- op 100011 (lw): ctrl 010. A=RD1. B=sext imm. WA=rt. MemToReg.
- op 101011 (sw): ctrl 010. A=RD1. B=sext imm. MemWrite. No RegWrite.
- op 000100 (beq): ctrl 110. A=RD1. B=RD2. No writes.
- Any other encoding: illegal. ctrl=`BUBBLE_CTRL`, A=B=0, WA=0, no writes, Valid=1, Illegal=1.

Write-back rule:
- WA==0 forces RegWrite=0. This makes nop (32'h0) a valid, harmless sll.

Bubble contents:
- ctrl=`BUBBLE_CTRL`, A=B=0, WA=0, RegWrite=MemWrite=MemToReg=0, Valid=0, Illegal=0.

Register update priority per edge:
- reset (async) > flush > stall > load decoded D.

## Timing
- Reset: every output takes the bubble value immediately on assertion, independent of `clk`.
- Latency: exactly 1 cycle. Decode is combinational in D; outputs change only on a `clk` edge or reset.
- `stall_E_i`=1: all outputs hold their current values, including Valid and Illegal.
- `flush_E_i`=1: a bubble is loaded, even when stall is also high.
- Reset deasserted mid-stall: the first edge after deassertion follows the normal priority (flush, then stall, then load).
- Operand width: immediates are extended to 32 bits before registering. shamt is zero-extended. No arithmetic is done here.
- Back-to-back instructions: one issue per cycle when not stalled. There are no internal wait states.

## Structure
- Shared package `p5_defs`:
  - ALU code constants (`ALU_AND` … `ALU_SLL`, `ALU_ZERO`), shared with the ALU.
  - opcode and funct constants.
  - `BUBBLE_CTRL` default.
- Sub-module `alu_dec`: purely combinational decoder from instruction plus RD1/RD2 to next-E fields.
- Top level: the E register bank and the reset/flush/stall priority.

## Test plan
- Reset asserted mid-cycle with E holding addu → all outputs go to the bubble value before the next edge; Valid=0, ctrl=011.
- `Instr`=0x00851021 (addu $2,$4,$5), RD1=7, RD2=5 → next edge: ctrl=010, A=7, B=5, WA=2, RegWrite=1, Valid=1.
- `Instr`=0x3C011234 (lui $1,0x1234) → A=0x00001234, B=16, ctrl=111, WA=1. `Instr`=0x8C22FFFC (lw $2,-4($1)), RD1=0x100 → B=0xFFFFFFFC, ctrl=010, MemToReg=1.
- Load sw, then hold stall=1 for 3 cycles while D changes → outputs stay sw; then stall=1 with flush=1 → bubble.
- `Instr`=0x00000000 → Valid=1, RegWrite=0. `Instr`=0xFC000000 → Illegal=1, ctrl=011, no writes.

Source files
------------

// File: rtl/p5_defs.sv
// ============================================================================
// Module : p5_defs
// Brief  : Shared P5 pipeline constants: ALU codes, opcodes, functs, E fields.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package p5_defs;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ZERO = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;

    localparam logic [2:0] BUBBLE_CTRL_DEF = ALU_ZERO;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [4:0]  wa;
        logic        regwrite;
        logic        memwrite;
        logic        memtoreg;
        logic        valid;
        logic        illegal;
    } e_fields_t;

    function automatic e_fields_t bubble_fields(input logic [2:0] ctrl);
        e_fields_t f;
        f          = '0;
        f.ctrl     = ctrl;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_dec.sv
// ============================================================================
// Module : alu_dec
// Brief  : Combinational D-stage decoder producing the next E-stage ALU fields.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_dec
    import p5_defs::*;
#(
    parameter logic [2:0] BUBBLE_CTRL = BUBBLE_CTRL_DEF
) (
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rd1,
    input  logic [31:0] i_rd2,
    output e_fields_t   o_fields
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [31:0] w_zext;
    logic [31:0] w_sext;
    logic        w_unused;
    e_fields_t   w_dec;

    assign w_op     = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    assign w_rt     = i_instr[20:16];
    assign w_rd     = i_instr[15:11];
    assign w_shamt  = i_instr[10:6];
    assign w_zext   = {16'h0000, i_instr[15:0]};
    assign w_sext   = {{16{i_instr[15]}}, i_instr[15:0]};
    // rs is not decoded: its value arrives already forwarded on i_rd1.
    assign w_unused = ^i_instr[25:21];

    always_comb begin
        w_dec         = bubble_fields(BUBBLE_CTRL);
        w_dec.valid   = 1'b1;
        w_dec.illegal = 1'b1;
        unique case (w_op)
            OP_RTYPE: begin
                if (w_funct == FN_ADDU || w_funct == FN_SUBU ||
                    w_funct == FN_AND  || w_funct == FN_OR) begin
                    w_dec.illegal  = 1'b0;
                    w_dec.srca     = i_rd1;
                    w_dec.srcb     = i_rd2;
                    w_dec.wa       = w_rd;
                    w_dec.regwrite = 1'b1;
                    unique case (w_funct)
                        FN_ADDU: w_dec.ctrl = ALU_ADD;
                        FN_SUBU: w_dec.ctrl = ALU_SUB;
                        FN_AND:  w_dec.ctrl = ALU_AND;
                        default: w_dec.ctrl = ALU_OR;
                    endcase
                end else if (w_funct == FN_SLL) begin
                    w_dec.illegal  = 1'b0;
                    w_dec.ctrl     = ALU_SLL;
                    w_dec.srca     = i_rd2;
                    w_dec.srcb     = {27'd0, w_shamt};
                    w_dec.wa       = w_rd;
                    w_dec.regwrite = 1'b1;
                end
            end
            OP_ORI: begin
                w_dec.illegal  = 1'b0;
                w_dec.ctrl     = ALU_OR;
                w_dec.srca     = i_rd1;
                w_dec.srcb     = w_zext;
                w_dec.wa       = w_rt;
                w_dec.regwrite = 1'b1;
            end
            OP_LUI: begin
                w_dec.illegal  = 1'b0;
                w_dec.ctrl     = ALU_SLL;
                w_dec.srca     = w_zext;
                w_dec.srcb     = 32'd16;
                w_dec.wa       = w_rt;
                w_dec.regwrite = 1'b1;
            end
            OP_LW: begin
                w_dec.illegal  = 1'b0;
                w_dec.ctrl     = ALU_ADD;
                w_dec.srca     = i_rd1;
                w_dec.srcb     = w_sext;
                w_dec.wa       = w_rt;
                w_dec.regwrite = 1'b1;
                w_dec.memtoreg = 1'b1;
            end
            OP_SW: begin
                w_dec.illegal  = 1'b0;
                w_dec.ctrl     = ALU_ADD;
                w_dec.srca     = i_rd1;
                w_dec.srcb     = w_sext;
                w_dec.memwrite = 1'b1;
            end
            OP_BEQ: begin
                w_dec.illegal  = 1'b0;
                w_dec.ctrl     = ALU_SUB;
                w_dec.srca     = i_rd1;
                w_dec.srcb     = i_rd2;
            end
            default: ;
        endcase
    end

    // Writes to $0 are dropped here so nop (sll $0,$0,0) stays harmless.
    always_comb begin
        o_fields          = w_dec;
        o_fields.regwrite = w_dec.regwrite & (|w_dec.wa);
    end

endmodule

`default_nettype wire

// File: rtl/de_alu_issue.sv
// ============================================================================
// Module : de_alu_issue
// Brief  : ALU decode/issue: D-stage decode into the E register bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module de_alu_issue
    import p5_defs::*;
#(
    parameter logic [2:0] BUBBLE_CTRL = BUBBLE_CTRL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_D_i,
    input  logic [31:0] RD1_D_i,
    input  logic [31:0] RD2_D_i,
    input  logic        stall_E_i,
    input  logic        flush_E_i,
    output logic [2:0]  ALU_ctrl_E_o,
    output logic [31:0] ALU_srca_E_o,
    output logic [31:0] ALU_srcb_E_o,
    output logic [4:0]  WA_E_o,
    output logic        RegWrite_E_o,
    output logic        MemWrite_E_o,
    output logic        MemToReg_E_o,
    output logic        Valid_E_o,
    output logic        Illegal_E_o
);

    e_fields_t w_next;
    e_fields_t r_e;

    alu_dec #(
        .BUBBLE_CTRL (BUBBLE_CTRL)
    ) u_alu_dec (
        .i_instr  (Instr_D_i),
        .i_rd1    (RD1_D_i),
        .i_rd2    (RD2_D_i),
        .o_fields (w_next)
    );

    // Flush wins over stall so a held stage can still be squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= bubble_fields(BUBBLE_CTRL);
        end else if (flush_E_i) begin
            r_e <= bubble_fields(BUBBLE_CTRL);
        end else if (!stall_E_i) begin
            r_e <= w_next;
        end
    end

    assign ALU_ctrl_E_o = r_e.ctrl;
    assign ALU_srca_E_o = r_e.srca;
    assign ALU_srcb_E_o = r_e.srcb;
    assign WA_E_o       = r_e.wa;
    assign RegWrite_E_o = r_e.regwrite;
    assign MemWrite_E_o = r_e.memwrite;
    assign MemToReg_E_o = r_e.memtoreg;
    assign Valid_E_o    = r_e.valid;
    assign Illegal_E_o  = r_e.illegal;

endmodule

`default_nettype wire
